// File: rtl/vnu_ser_if.sv
// Handshake bundle for the serial variable-node unit: check messages in, extrinsic messages out.
interface vnu_ser_if #(
    parameter int RES_W  = 8,
    parameter int DATA_W = 11
);
    logic              in_valid;
    logic              in_ready;
    logic [RES_W-1:0]  llr;
    logic [RES_W-1:0]  r_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_q;
    logic              out_last;
    logic              hd_bit;
    logic              hd_valid;

    modport master (
        output in_valid, llr, r_in, out_ready,
        input  in_ready, out_valid, out_q, out_last, hd_bit, hd_valid
    );

    modport slave (
        input  in_valid, llr, r_in, out_ready,
        output in_ready, out_valid, out_q, out_last, hd_bit, hd_valid
    );
endinterface

// File: rtl/vnu_ser.sv
// Serial variable-node unit: accumulates llr + sum(r) over DV beats, then emits q_j = total - r_j.
// Optional hard-decision output enabled by defining VNU_HARD_DEC_EN.
module vnu_ser #(
    parameter int DV    = 3,
    parameter int res_w = 8,
    parameter int ext_w = 3,
    parameter int cnt_w = 2
) (
    input  logic     clk,
    input  logic     rst,
    vnu_ser_if.slave bus
);
    localparam int DATA_W = res_w + ext_w;
    localparam int ACC_W  = res_w + cnt_w + 1;
    localparam int SW     = ACC_W + DATA_W + 1;
    localparam logic [cnt_w-1:0] KMAX = cnt_w'(DV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic        [res_w-1:0] r_buf [DV];
    logic        [cnt_w-1:0] r_k;
    logic        [cnt_w-1:0] w_k_inc;
    logic signed [ACC_W-1:0] w_acc_add;
    logic signed [ACC_W-1:0] w_acc_first;
    logic signed [SW-1:0]    w_diff;
    logic        [res_w-1:0] w_buf_k;
    logic                    w_last_in;

    function automatic logic signed [ACC_W-1:0] sext_res(input logic [res_w-1:0] v);
        return {{(ACC_W-res_w){v[res_w-1]}}, v};
    endfunction

    // Symmetric clamp: the most negative code is never produced.
    function automatic logic [DATA_W-1:0] sat_q(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] lim;
        logic signed [SW-1:0] nlim;
        lim  = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        nlim = -lim;
        if (v > lim) begin
            sat_q = lim[DATA_W-1:0];
        end else if (v < nlim) begin
            sat_q = nlim[DATA_W-1:0];
        end else begin
            sat_q = v[DATA_W-1:0];
        end
    endfunction

    assign w_k_inc     = (r_k == KMAX) ? {cnt_w{1'b0}} : r_k + cnt_w'(1);
    assign w_acc_add   = r_acc + sext_res(bus.r_in);
    assign w_acc_first = sext_res(bus.llr) + sext_res(bus.r_in);
    assign w_buf_k     = r_buf[r_k];
    assign w_diff      = {{(SW-ACC_W){r_acc[ACC_W-1]}}, r_acc}
                       - {{(SW-res_w){w_buf_k[res_w-1]}}, w_buf_k};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode, from registered state only on the output side.
    always_comb begin
        w_state_nxt   = r_state;
        w_last_in     = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_q     = {DATA_W{1'b0}};
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_ACC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACC: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && (r_k == KMAX)) begin
                    w_last_in   = 1'b1;
                    w_state_nxt = S_EMIT;
                end else begin
                    w_state_nxt = S_ACC;
                end
            end
            S_EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_q     = sat_q(w_diff);
                bus.out_last  = (r_k == KMAX);
                if (bus.out_ready && (r_k == KMAX)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulator, message buffer and edge counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= {ACC_W{1'b0}};
            r_k   <= {cnt_w{1'b0}};
            for (int i = 0; i < DV; i++) begin
                r_buf[i] <= {res_w{1'b0}};
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_acc    <= w_acc_first;
                        r_buf[0] <= bus.r_in;
                        r_k      <= cnt_w'(1);
                    end
                end
                S_ACC: begin
                    if (bus.in_valid) begin
                        r_acc      <= w_acc_add;
                        r_buf[r_k] <= bus.r_in;
                        r_k        <= w_k_inc;
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        r_k <= w_k_inc;
                    end
                end
                default: begin
                    r_k <= {cnt_w{1'b0}};
                end
            endcase
        end
    end

`ifdef VNU_HARD_DEC_EN
    logic r_hd_bit;
    logic r_hd_valid;

    // Hard decision captured from the completed total as EMIT is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hd_bit   <= 1'b0;
            r_hd_valid <= 1'b0;
        end else begin
            r_hd_valid <= w_last_in;
            if (w_last_in) begin
                r_hd_bit <= w_acc_add[ACC_W-1];
            end
        end
    end

    assign bus.hd_bit   = r_hd_bit;
    assign bus.hd_valid = r_hd_valid;
`else
    assign bus.hd_bit   = 1'b0;
    assign bus.hd_valid = 1'b0;
`endif

endmodule
